// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types and constants for the SHA-256 message padder
package sha256_pkg;

  typedef enum logic [1:0] {
    DATA  = 2'd0,
    PAD80 = 2'd1,
    ZERO  = 2'd2,
    LEN   = 2'd3
  } state_t;

  typedef logic [7:0] byte_t;

  localparam int         BLOCK_BYTES = 64;
  localparam logic [5:0] LEN_POS     = 6'd56;
  localparam logic [5:0] LAST_IDX    = 6'(BLOCK_BYTES - 1);
  localparam byte_t      PAD_BYTE    = 8'h80;

endpackage

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - byte-serial FIPS 180-4 message padder emitting 64-byte blocks
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int CNT_W = 61
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  input  logic       in_empty,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_first,
  output logic       out_blk_last,
  output logic       out_msg_last
);

  state_t             state_q, state_d;
  logic [5:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [5:0]         idx_inc;
  logic [63:0]        bit_len;
  logic [63:0]        len_shift;

  assign idx_inc = idx_q + 6'd1;
  // Bit length is the byte count times eight; idx[2:0]==0 selects the MSB byte.
  assign bit_len   = 64'({count_q, 3'b000});
  assign len_shift = bit_len >> {~idx_q[2:0], 3'b000};

  // Next-state, counter updates and handshake outputs; everything is idle while in reset.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    if (reset_n) begin
      unique case (state_q)
        DATA: begin
          if (in_valid && in_last && in_empty) begin
            // Zero-length message marker: swallow the beat without emitting anything.
            in_ready = 1'b1;
            state_d  = PAD80;
          end else begin
            out_valid = in_valid;
            out_data  = in_data;
            in_ready  = out_ready;
            if (in_valid && out_ready) begin
              idx_d   = idx_inc;
              count_d = count_q + CNT_W'(1);
              if (in_last) state_d = PAD80;
            end
          end
        end
        PAD80: begin
          out_valid = 1'b1;
          out_data  = PAD_BYTE;
          if (out_ready) begin
            idx_d   = idx_inc;
            state_d = (idx_inc == LEN_POS) ? LEN : ZERO;
          end
        end
        ZERO: begin
          out_valid = 1'b1;
          if (out_ready) begin
            idx_d = idx_inc;
            if (idx_inc == LEN_POS) state_d = LEN;
          end
        end
        LEN: begin
          out_valid = 1'b1;
          out_data  = len_shift[7:0];
          if (out_ready) begin
            idx_d = idx_inc;
            if (idx_q == LAST_IDX) begin
              state_d = DATA;
              idx_d   = 6'd0;
              count_d = '0;
            end
          end
        end
        default: state_d = DATA;
      endcase
    end
  end

  // Block framing strobes derived from the position within the current block.
  always_comb begin
    out_first    = out_valid && (idx_q == 6'd0);
    out_blk_last = out_valid && (idx_q == LAST_IDX);
    out_msg_last = out_blk_last && (state_q == LEN);
  end

  // State, block position and message byte count registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= DATA;
      idx_q   <= 6'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - self-checking bench for the SHA-256 message padder
module tb_sha256_msg_padder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_empty;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_first;
  logic       out_blk_last;
  logic       out_msg_last;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  msg_q[$];
  logic [10:0] exp_q[$];
  logic [10:0] got_q[$];

  typedef struct {
    int         n;
    bit         aa;
    bit         rr;
    int         total;
    int         p0;
    logic [7:0] b0;
    int         p1;
    logic [7:0] b1;
    int         p2;
    logic [7:0] b2;
  } vec_t;

  vec_t vecs[6];

  sha256_msg_padder #(.CNT_W(61)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_empty     (in_empty),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_first    (out_first),
    .out_blk_last (out_blk_last),
    .out_msg_last (out_msg_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Padded stream from the message: data, 0x80, zeros, 64-bit big-endian bit length.
  task automatic build_expected();
    int n, total;
    logic [63:0] bitlen;
    logic [7:0]  b;
    n      = msg_q.size();
    total  = ((n + 9 + 63) / 64) * 64;
    bitlen = 64'(n) * 64'd8;
    exp_q.delete();
    for (int i = 0; i < total; i++) begin
      if (i < n)               b = msg_q[i];
      else if (i == n)         b = 8'h80;
      else if (i >= total - 8) b = 8'(bitlen >> (8 * (total - 1 - i)));
      else                     b = 8'h00;
      exp_q.push_back({(i % 64) == 0, (i % 64) == 63, i == total - 1, b});
    end
  endtask

  task automatic run_msg(input bit rand_rdy);
    int ip, cyc;
    bit done, pstall, empty_msg;
    logic [10:0] prev;
    got_q.delete();
    ip = 0; cyc = 0; done = 0; pstall = 0; prev = '0;
    empty_msg = (msg_q.size() == 0);
    while (!done && cyc < 5000) begin
      if (empty_msg) begin
        in_valid = (ip == 0); in_data = 8'h00; in_last = 1'b1; in_empty = 1'b1;
      end else if (ip < msg_q.size()) begin
        in_valid = 1'b1; in_data = msg_q[ip]; in_last = (ip == msg_q.size() - 1); in_empty = 1'b0;
      end else begin
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; in_empty = 1'b0;
      end
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (pstall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_hold", 64'({out_first, out_blk_last, out_msg_last, out_data}), 64'(prev));
      end
      pstall = out_valid && !out_ready;
      prev   = {out_first, out_blk_last, out_msg_last, out_data};
      if (out_valid && out_ready) begin
        got_q.push_back(prev);
        if (out_msg_last) done = 1;
      end
      if (in_valid && in_ready) ip++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0; out_ready = 1'b1;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: got %0d bytes, no out_msg_last", got_q.size());
    end
  endtask

  task automatic compare_stream(input string tag);
    int m;
    check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      check($sformatf("%s_byte%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic spot(input string tag, input int pos, input logic [7:0] b);
    if (pos < got_q.size()) check($sformatf("%s_pos%0d", tag, pos), 64'(got_q[pos][7:0]), 64'(b));
    else begin
      n_tests++; n_fail++;
      $display("FAIL %s_pos%0d: stream has %0d bytes, expected %0h", tag, pos, got_q.size(), b);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ov"}, 64'(out_valid), 64'd0);
    check({tag, "_ir"}, 64'(in_ready), 64'd0);
    check({tag, "_od"}, 64'(out_data), 64'd0);
    check({tag, "_st"}, 64'({out_first, out_blk_last, out_msg_last}), 64'd0);
  endtask

  initial begin
    vecs[0] = '{0,  1'b0, 1'b0, 64,  0,  8'h80, 63,  8'h00, 1,   8'h00};
    vecs[1] = '{3,  1'b0, 1'b0, 64,  3,  8'h80, 63,  8'h18, 0,   8'h61};
    vecs[2] = '{55, 1'b1, 1'b0, 64,  55, 8'h80, 62,  8'h01, 63,  8'hB8};
    vecs[3] = '{56, 1'b1, 1'b0, 128, 56, 8'h80, 126, 8'h01, 127, 8'hC0};
    vecs[4] = '{64, 1'b0, 1'b1, 128, 64, 8'h80, 126, 8'h02, 127, 8'h00};
    vecs[5] = '{63, 1'b1, 1'b1, 128, 63, 8'h80, 126, 8'h01, 127, 8'hF8};

    reset_n = 1'b0; in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1; in_empty = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    reset_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      msg_q.delete();
      for (int i = 0; i < vecs[v].n; i++)
        msg_q.push_back(vecs[v].aa ? 8'hAA : 8'(8'h61 + i));
      build_expected();
      run_msg(vecs[v].rr);
      check({tag, "_total"}, 64'(got_q.size()), 64'(vecs[v].total));
      spot(tag, vecs[v].p0, vecs[v].b0);
      spot(tag, vecs[v].p1, vecs[v].b1);
      spot(tag, vecs[v].p2, vecs[v].b2);
      compare_stream(tag);
    end

    // Reset in the middle of a message, then a fresh "abc".
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h61 + i); in_last = 1'b0; in_empty = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      if (i == 0) check("midrst_accept", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    @(negedge clk);
    check_idle("midrst");
    @(posedge clk); #1;
    reset_n = 1'b1; in_valid = 1'b0;
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    build_expected();
    run_msg(1'b0);
    spot("midrst", 63, 8'h18);
    spot("midrst", 3, 8'h80);
    compare_stream("midrst");

    // Random messages against the model, with random backpressure.
    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(0, 140);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
      build_expected();
      run_msg(1'b1);
      compare_stream($sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
